// File: rtl/acq_trigger_ctrl.sv
// Acquisition trigger sequencer: sample-tick decimation, trigger detection and capture windowing.
// Define ACQ_TRIG_COUNTER_EN to implement the TRIG_CNT register at BASE_ADDR+5.
module acq_trigger_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BASE_ADDR  = 32'h4100,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  addr_en,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  adc_clk,
  input  logic                  sync_signal_in,
  input  logic                  capture_done,
  output logic                  stable,
  output logic                  sample_tick,
  output logic                  trigger,
  output logic                  capture_active
);

  localparam logic [DATA_WIDTH-1:0] Base    = DATA_WIDTH'(BASE_ADDR);
  localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CntMax  = '1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArmed   = 3'd1,
    StCapture = 3'd2,
    StHoldoff = 3'd3
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [CNT_WIDTH-1:0]  decim_q, holdoff_q, timeout_q;
  logic [CNT_WIDTH-1:0]  dcnt_q, tcnt_q, hcnt_q;
  logic                  adc_prev_q, cmp_prev_q, edge_q;
  logic [DATA_WIDTH-1:0] off, rdata, trig_cnt_rd;
  logic                  hit, bus_wr, wr_ctrl;
  logic                  adc_rise, edge_match, fire, trig_fire, hold_done, clr_run;

  // Register decode always uses the latched address, so a same-cycle addr_en sees the old one.
  assign off     = addr_q - Base;
  assign hit     = (addr_q >= Base) && (off < DATA_WIDTH'(6));
  assign bus_wr  = en && rd_en && hit;
  assign wr_ctrl = bus_wr && (off[2:0] == 3'd0);

  assign hold_done = (hcnt_q == holdoff_q);
  assign fire      = (state_q == StArmed) &&
                     (edge_q || (ctrl_q[3:2] == 2'b11) ||
                      ((timeout_q != '0) && (tcnt_q == timeout_q)));

  always_comb begin
    ctrl_d    = wr_ctrl ? rd_data[3:0] : ctrl_q;
    trig_fire = fire && ctrl_d[0];
    clr_run   = (state_q == StHoldoff) && hold_done && ctrl_d[1] && ctrl_d[0];
  end

  always_comb begin
    rdata = '1;
    if (hit) begin
      case (off[2:0])
        3'd0:    rdata = DATA_WIDTH'(ctrl_q);
        3'd1:    rdata = DATA_WIDTH'(decim_q);
        3'd2:    rdata = DATA_WIDTH'(holdoff_q);
        3'd3:    rdata = DATA_WIDTH'(timeout_q);
        3'd4:    rdata = {{(DATA_WIDTH-3){1'b0}}, state_q};
        3'd5:    rdata = trig_cnt_rd;
        default: rdata = '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      ctrl_q    <= '0;
      decim_q   <= '0;
      holdoff_q <= '0;
      timeout_q <= '0;
      wr_data   <= '1;
    end else begin
      if (en && addr_en) addr_q <= rd_data;
      ctrl_q <= clr_run ? {ctrl_d[3:1], 1'b0} : ctrl_d;
      if (bus_wr && (off[2:0] == 3'd1)) decim_q   <= CNT_WIDTH'(rd_data);
      if (bus_wr && (off[2:0] == 3'd2)) holdoff_q <= CNT_WIDTH'(rd_data);
      if (bus_wr && (off[2:0] == 3'd3)) timeout_q <= CNT_WIDTH'(rd_data);
      if (en && wr_en) wr_data <= rdata;
    end
  end

`ifdef ACQ_TRIG_COUNTER_EN
  logic [DATA_WIDTH-1:0] trig_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_cnt_q <= '0;
    end else if (bus_wr && (off[2:0] == 3'd5)) begin
      trig_cnt_q <= '0;
    end else if (trig_fire) begin
      trig_cnt_q <= trig_cnt_q + DATA_WIDTH'(1);
    end
  end

  assign trig_cnt_rd = trig_cnt_q;
`else
  assign trig_cnt_rd = '1;
`endif

  // Sample-tick decimator runs freely, independent of the sequencer state.
  assign adc_rise = adc_clk && !adc_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_prev_q  <= 1'b0;
      dcnt_q      <= '0;
      sample_tick <= 1'b0;
    end else begin
      adc_prev_q  <= adc_clk;
      sample_tick <= 1'b0;
      if (adc_rise) begin
        if (dcnt_q == decim_q) begin
          sample_tick <= 1'b1;
          dcnt_q      <= '0;
        end else begin
          dcnt_q <= dcnt_q + CntOne;
        end
      end
    end
  end

  always_comb begin
    edge_match = 1'b0;
    case (ctrl_q[3:2])
      2'b00:   edge_match = sync_signal_in && !cmp_prev_q;
      2'b01:   edge_match = !sync_signal_in && cmp_prev_q;
      2'b10:   edge_match = sync_signal_in ^ cmp_prev_q;
      default: edge_match = 1'b0;
    endcase
  end

  // Registering the match gives the two-clock edge-to-trigger latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_prev_q <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      cmp_prev_q <= sync_signal_in;
      edge_q     <= edge_match;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      tcnt_q         <= '0;
      hcnt_q         <= '0;
      trigger        <= 1'b0;
      stable         <= 1'b0;
      capture_active <= 1'b0;
    end else begin
      trigger <= 1'b0;
      if (!ctrl_d[0]) begin
        state_q        <= StIdle;
        stable         <= 1'b0;
        capture_active <= 1'b0;
        tcnt_q         <= '0;
        hcnt_q         <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StArmed;
            stable  <= 1'b1;
            tcnt_q  <= '0;
          end
          StArmed: begin
            if (trig_fire) begin
              trigger        <= 1'b1;
              state_q        <= StCapture;
              capture_active <= 1'b1;
            end else if (sample_tick && (tcnt_q != CntMax)) begin
              tcnt_q <= tcnt_q + CntOne;
            end
          end
          StCapture: begin
            if (capture_done) begin
              state_q        <= StHoldoff;
              stable         <= 1'b0;
              capture_active <= 1'b0;
              hcnt_q         <= '0;
            end
          end
          StHoldoff: begin
            if (hold_done) begin
              if (ctrl_d[1]) begin
                state_q <= StIdle;
              end else begin
                state_q <= StArmed;
                stable  <= 1'b1;
                tcnt_q  <= '0;
              end
            end else if (sample_tick && (hcnt_q != CntMax)) begin
              hcnt_q <= hcnt_q + CntOne;
            end
          end
          default: begin
            state_q        <= StIdle;
            stable         <= 1'b0;
            capture_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
